ansi_seq_encoder: RTL and testbench

- Transmit-side counterpart of the terminal command decoder: converts a command request (code plus up to two numeric arguments) into the ANSI/VT100 CSI byte sequence.
- Bytes are handed one at a time to the serial TX path over a valid/ready handshake.
- Sits between the host-side control logic and the UART transmitter, so the FPGA can drive a remote terminal with the same command set it decodes.

---
 rtl/ansi_pkg.sv | 100 ++++++++++
 rtl/bin2dec2.sv | 27 ++
 rtl/ansi_seq_encoder.sv | 142 ++++++++++++++
 tb/tb_ansi_seq_encoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ansi_pkg.sv
// Command set, FSM states and byte constants shared by the ANSI/VT100
// CSI encoder and its decoder counterpart.
package ansi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned ARG_W  = 7;
  localparam int unsigned DIG_W  = 4;

  // Command codes; 14 and 15 are undefined.
  typedef enum logic [CODE_W-1:0] {
    DELETE = 4'd0,
    CUF    = 4'd1,
    CUB    = 4'd2,
    CNL    = 4'd3,
    CPL    = 4'd4,
    CHA    = 4'd5,
    CUP    = 4'd6,
    ED     = 4'd7,
    EL     = 4'd8,
    SU     = 4'd9,
    SD     = 4'd10,
    HVP    = 4'd11,
    SCP    = 4'd12,
    RCP    = 4'd13
  } cmd_t;

  localparam logic [CODE_W-1:0] LAST_CODE = 4'd13;

  // Argument shape of a command.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_ONE  = 2'd1,
    K_TWO  = 2'd2,
    K_DEL  = 2'd3
  } kind_t;

  // Encoder FSM: one state per emitted byte position.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ESC  = 4'd1,
    S_LBR  = 4'd2,
    S_A1_T = 4'd3,
    S_A1_O = 4'd4,
    S_SEMI = 4'd5,
    S_A2_T = 4'd6,
    S_A2_O = 4'd7,
    S_FIN  = 4'd8
  } state_t;

  localparam logic [BYTE_W-1:0] ESC     = 8'h1B;
  localparam logic [BYTE_W-1:0] LBR     = 8'h5B;
  localparam logic [BYTE_W-1:0] SEMI    = 8'h3B;
  localparam logic [BYTE_W-1:0] TILDE   = 8'h7E;
  localparam logic [BYTE_W-1:0] ASCII_0 = 8'h30;

  // Final (command letter) byte of each sequence.
  function automatic logic [BYTE_W-1:0] final_byte(input cmd_t c);
    logic [BYTE_W-1:0] b;
    case (c)
      DELETE:  b = TILDE;
      CUF:     b = 8'h43;
      CUB:     b = 8'h44;
      CNL:     b = 8'h45;
      CPL:     b = 8'h46;
      CHA:     b = 8'h47;
      CUP:     b = 8'h48;
      ED:      b = 8'h4A;
      EL:      b = 8'h4B;
      SU:      b = 8'h53;
      SD:      b = 8'h54;
      HVP:     b = 8'h66;
      SCP:     b = 8'h73;
      RCP:     b = 8'h75;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // How many numeric fields a command carries.
  function automatic kind_t cmd_kind(input cmd_t c);
    kind_t k;
    case (c)
      DELETE:   k = K_DEL;
      CUP, HVP: k = K_TWO;
      SCP, RCP: k = K_NONE;
      default:  k = K_ONE;
    endcase
    return k;
  endfunction

  function automatic logic code_defined(input logic [CODE_W-1:0] c);
    return c <= LAST_CODE;
  endfunction

  function automatic logic [BYTE_W-1:0] digit_byte(input logic [DIG_W-1:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2dec2.sv
// Combinational 7-bit binary to two BCD digits, clamped to MAX_ARG.
// Ports: value (binary in), tens / ones (BCD digits out).
module bin2dec2
  import ansi_pkg::*;
#(
  parameter int unsigned MAX_ARG = 99
) (
  input  logic [ARG_W-1:0] value,
  output logic [DIG_W-1:0] tens,
  output logic [DIG_W-1:0] ones
);

  // Clamp, then nine compare-subtract stages peel off the tens.
  always_comb begin
    logic [ARG_W-1:0] rem;
    rem  = (value > ARG_W'(MAX_ARG)) ? ARG_W'(MAX_ARG) : value;
    tens = '0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[DIG_W-1:0];
  end

endmodule

// File: rtl/ansi_seq_encoder.sv
// Converts a command request (code + up to two arguments) into the
// ANSI/VT100 CSI byte sequence, one byte per valid/ready handshake.
// Ports:
//   clk, _rst                   clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_code, cmd_arg1/2        command code and numeric arguments
//   tx_data/tx_valid/tx_ready   byte stream to the UART transmitter
//   done                        pulse after the final byte is taken
//   bad_cmd                     pulse after an undefined code is dropped
module ansi_seq_encoder
  import ansi_pkg::*;
#(
  parameter int unsigned MAX_ARG = 99
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CODE_W-1:0] cmd_code,
  input  logic [ARG_W-1:0]  cmd_arg1,
  input  logic [ARG_W-1:0]  cmd_arg2,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done,
  output logic              bad_cmd
);

  state_t              state;
  logic [CODE_W-1:0]   code_q;
  logic [ARG_W-1:0]    arg1_q;
  logic [ARG_W-1:0]    arg2_q;
  logic [DIG_W-1:0]    tens1;
  logic [DIG_W-1:0]    ones1;
  logic [DIG_W-1:0]    tens2;
  logic [DIG_W-1:0]    ones2;
  kind_t               kind;
  state_t              adv_state;
  logic [BYTE_W-1:0]   adv_byte;
  logic                arg1_zero;

  bin2dec2 #(.MAX_ARG(MAX_ARG)) u_dec1 (
    .value (arg1_q),
    .tens  (tens1),
    .ones  (ones1)
  );

  bin2dec2 #(.MAX_ARG(MAX_ARG)) u_dec2 (
    .value (arg2_q),
    .tens  (tens2),
    .ones  (ones2)
  );

  assign kind      = cmd_kind(cmd_t'(code_q));
  assign arg1_zero = (tens1 == 4'd0) && (ones1 == 4'd0);

  // Successor of the byte currently presented; unused positions are skipped.
  always_comb begin
    adv_state = S_IDLE;
    case (state)
      S_ESC: adv_state = S_LBR;
      S_LBR: begin
        case (kind)
          K_DEL:   adv_state = S_A1_O;
          K_NONE:  adv_state = S_FIN;
          K_TWO:   adv_state = (tens1 != 4'd0) ? S_A1_T : S_A1_O;
          default: begin
            // Single-argument commands omit a zero argument entirely.
            if (arg1_zero)            adv_state = S_FIN;
            else if (tens1 != 4'd0)   adv_state = S_A1_T;
            else                      adv_state = S_A1_O;
          end
        endcase
      end
      S_A1_T:  adv_state = S_A1_O;
      S_A1_O:  adv_state = (kind == K_TWO) ? S_SEMI : S_FIN;
      S_SEMI:  adv_state = (tens2 != 4'd0) ? S_A2_T : S_A2_O;
      S_A2_T:  adv_state = S_A2_O;
      S_A2_O:  adv_state = S_FIN;
      default: adv_state = S_IDLE;
    endcase
  end

  // Byte emitted in the successor state.
  always_comb begin
    adv_byte = 8'h00;
    case (adv_state)
      S_ESC:   adv_byte = ESC;
      S_LBR:   adv_byte = LBR;
      S_A1_T:  adv_byte = digit_byte(tens1);
      // DELETE reuses the ones slot for its fixed '3'.
      S_A1_O:  adv_byte = (kind == K_DEL) ? digit_byte(4'd3) : digit_byte(ones1);
      S_SEMI:  adv_byte = SEMI;
      S_A2_T:  adv_byte = digit_byte(tens2);
      S_A2_O:  adv_byte = digit_byte(ones2);
      S_FIN:   adv_byte = final_byte(cmd_t'(code_q));
      default: adv_byte = 8'h00;
    endcase
  end

  // Sequencer: accept in idle, advance one position per accepted byte.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      state     <= S_IDLE;
      code_q    <= '0;
      arg1_q    <= '0;
      arg2_q    <= '0;
      cmd_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      done      <= 1'b0;
      bad_cmd   <= 1'b0;
    end else begin
      done    <= 1'b0;
      bad_cmd <= 1'b0;
      if (state == S_IDLE) begin
        if (cmd_valid && cmd_ready) begin
          if (code_defined(cmd_code)) begin
            code_q    <= cmd_code;
            arg1_q    <= cmd_arg1;
            arg2_q    <= cmd_arg2;
            state     <= S_ESC;
            tx_data   <= ESC;
            tx_valid  <= 1'b1;
            cmd_ready <= 1'b0;
          end else begin
            bad_cmd <= 1'b1;
          end
        end
      end else if (tx_valid && tx_ready) begin
        state   <= adv_state;
        tx_data <= adv_byte;
        if (adv_state == S_IDLE) begin
          tx_valid  <= 1'b0;
          cmd_ready <= 1'b1;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ansi_seq_encoder.sv
// Self-checking bench for ansi_seq_encoder: a byte-list model of each
// command is compared against the DUT every cycle, plus literal vectors.
module tb_ansi_seq_encoder;

  localparam int unsigned MAX_ARG = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_code;
  logic [6:0] cmd_arg1;
  logic [6:0] cmd_arg2;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       bad_cmd;

  int n_vec = 0;
  int n_err = 0;

  logic       chk_en   = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] gen_q[$];
  logic       exp_done = 1'b0;
  logic       exp_bad  = 1'b0;
  logic [63:0] got_pk  = '0;
  int          got_n   = 0;

  // Final letter per code 0..13.
  logic [7:0] fin_tab [14] = '{8'h7E, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
                               8'h4A, 8'h4B, 8'h53, 8'h54, 8'h66, 8'h73, 8'h75};

  always #5 clk = ~clk;

  ansi_seq_encoder #(.MAX_ARG(MAX_ARG)) dut (
    .clk       (clk),
    ._rst      (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_arg1  (cmd_arg1),
    .cmd_arg2  (cmd_arg2),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (done),
    .bad_cmd   (bad_cmd)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the byte list a command must produce, built from the text rules.
  function automatic void gen(input logic [3:0] c, input logic [6:0] a1, input logic [6:0] a2);
    int v[2];
    int nargs;
    v[0] = (int'(a1) > int'(MAX_ARG)) ? int'(MAX_ARG) : int'(a1);
    v[1] = (int'(a2) > int'(MAX_ARG)) ? int'(MAX_ARG) : int'(a2);
    gen_q.delete();
    gen_q.push_back(8'h1B);
    gen_q.push_back(8'h5B);
    if (c == 4'd0) gen_q.push_back(8'h33);
    if (c == 4'd6 || c == 4'd11)                        nargs = 2;
    else if (c != 4'd0 && c != 4'd12 && c != 4'd13 && v[0] != 0) nargs = 1;
    else                                                 nargs = 0;
    for (int i = 0; i < nargs; i++) begin
      if (v[i] >= 10) gen_q.push_back(8'(48 + v[i] / 10));
      gen_q.push_back(8'(48 + v[i] % 10));
      if (i == 0 && nargs == 2) gen_q.push_back(8'h3B);
    end
    gen_q.push_back(fin_tab[c]);
  endfunction

  function automatic logic [63:0] pack_gen();
    logic [63:0] r = '0;
    foreach (gen_q[i]) r = {r[55:0], gen_q[i]};
    return r;
  endfunction

  // Per-cycle compare against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() == 0));
        chk("tx_valid", 64'(tx_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("tx_data", 64'(tx_data), 64'(exp_q[0]));
        chk("done", 64'(done), 64'(exp_done));
        chk("bad_cmd", 64'(bad_cmd), 64'(exp_bad));
        exp_done = 1'b0;
        exp_bad  = 1'b0;
        if (rst && tx_valid && tx_ready) begin
          got_pk = {got_pk[55:0], tx_data};
          got_n++;
        end
        if (!rst) begin
          exp_q.delete();
        end else if (exp_q.size() != 0) begin
          if (tx_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end else if (cmd_valid) begin
          if (cmd_code > 4'd13) exp_bad = 1'b1;
          else begin
            gen(cmd_code, cmd_arg1, cmd_arg2);
            foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
          end
        end
      end
    end
  end

  task automatic chk_seq(input string name, input int n, input logic [63:0] pk);
    chk({name, "_len"}, 64'(got_n), 64'(n));
    chk({name, "_bytes"}, got_pk, pk);
    got_n  = 0;
    got_pk = '0;
  endtask

  // Present a command (caller sits just after a rising edge); returns in
  // the cycle after the accept edge with the inputs scrambled.
  task automatic issue(input logic [3:0] c, input logic [6:0] a1, input logic [6:0] a2);
    int n = 0;
    cmd_code  = c;
    cmd_arg1  = a1;
    cmd_arg2  = a2;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_code  = 4'($urandom);
    cmd_arg1  = 7'($urandom);
    cmd_arg2  = 7'($urandom);
  endtask

  // Drive tx_ready cyclically from pat (bit i%4) until done is seen.
  task automatic wait_done(input logic [3:0] pat);
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      else tx_ready = pat[i % 4];
    end
    if (!seen) chk("done_timeout", 64'(done), 64'd1);
    tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = '0;
    cmd_arg1  = '0;
    cmd_arg2  = '0;
    tx_ready  = 1'b1;

    // Pin the model with hand-computed sequences.
    gen(4'd6, 7'd12, 7'd5);
    chk("model_cup", pack_gen(), 64'h001B5B31323B3548);
    gen(4'd1, 7'd0, 7'd0);
    chk("model_cuf0", pack_gen(), 64'h1B5B43);
    gen(4'd11, 7'd0, 7'd120);
    chk("model_hvp", pack_gen(), 64'h001B5B303B393966);
    gen(4'd0, 7'd55, 7'd66);
    chk("model_del", pack_gen(), 64'h1B5B337E);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'h00);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bad_cmd", 64'(bad_cmd), 64'd0);
    chk_en = 1'b1;
    rst    = 1'b1;
    @(posedge clk); #1;

    issue(4'd6, 7'd12, 7'd5);
    chk("cup_first_byte", 64'(tx_data), 64'h1B);
    wait_done(4'b1111);
    chk_seq("cup", 7, 64'h001B5B31323B3548);

    issue(4'd1, 7'd0, 7'd0);
    wait_done(4'b1111);
    chk_seq("cuf0", 3, 64'h1B5B43);

    issue(4'd1, 7'd7, 7'd0);
    wait_done(4'b1111);
    chk_seq("cuf7", 4, 64'h1B5B3743);

    issue(4'd0, 7'd0, 7'd0);
    wait_done(4'b1001);
    chk_seq("delete_stall", 4, 64'h1B5B337E);

    issue(4'd11, 7'd0, 7'd120);
    wait_done(4'b1111);
    chk_seq("hvp_clamp", 7, 64'h001B5B303B393966);

    issue(4'd5, 7'd100, 7'd0);
    wait_done(4'b0101);
    chk_seq("cha_clamp", 5, 64'h1B5B393947);

    issue(4'd10, 7'd10, 7'd0);
    wait_done(4'b1111);
    chk_seq("sd10", 5, 64'h1B5B313054);

    issue(4'd13, 7'd42, 7'd42);
    wait_done(4'b1111);
    chk_seq("rcp", 3, 64'h1B5B75);

    issue(4'd15, 7'd3, 7'd3);
    chk("bad_pulse", 64'(bad_cmd), 64'd1);
    chk("bad_no_tx", 64'(tx_valid), 64'd0);
    chk("bad_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    chk("bad_pulse_end", 64'(bad_cmd), 64'd0);
    issue(4'd14, 7'd0, 7'd0);
    @(posedge clk); #1;

    // Reset after the third byte of CUP is consumed.
    issue(4'd6, 7'd12, 7'd5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_tx_valid", 64'(tx_valid), 64'd0);
    chk("rstmid_ready", 64'(cmd_ready), 64'd1);
    chk("rstmid_done", 64'(done), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_no_done", 64'(done), 64'd0);
    chk_seq("rstmid", 3, 64'h1B5B31);

    // Back-to-back: EL(2) then SCP with cmd_valid held high.
    cmd_code  = 4'd8;
    cmd_arg1  = 7'd2;
    cmd_arg2  = 7'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_code = 4'd12;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("b2b_done_seen", 64'(seen), 64'd1);
    chk("b2b_ready_in_done", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_second_valid", 64'(tx_valid), 64'd1);
    chk("b2b_second_esc", 64'(tx_data), 64'h1B);
    wait_done(4'b1111);
    chk_seq("b2b", 7, 64'h001B5B324B1B5B73);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
